custom_axi_result_fifo: RTL and testbench

Downstream result buffer for the custom AXI IP datapath. It captures each completed result word the processing core emits on its `dout`/`enable_out` outputs and holds it in a first-word-fall-through FIFO. The AXI-lite read path drains the FIFO through a valid/ready handshake. It also tracks occupancy, a watermark interrupt, and sticky overflow and protocol-error flags.

---
 rtl/custom_axi_result_fifo.sv | 163 ++++++++++++++++
 tb/tb_custom_axi_result_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_result_fifo.sv
// -----------------------------------------------------------------------------
// custom_axi_result_fifo
//
// Downstream result buffer for the custom AXI IP datapath. Results from the
// processing core are captured into a first-word-fall-through FIFO that the
// AXI-lite read path drains with a valid/ready handshake. Occupancy, a
// watermark interrupt and sticky overflow / protocol-error flags are tracked.
//
// Optional feature macro: CUSTOM_AXI_RESULT_FIFO_STATS_EN
//   When defined, adds saturating push / drop statistics counters.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   res_data_i   in   [DATA_WIDTH:1] payload, [0] result-valid flag
//   res_en_i     in   core enable: 01 result present, 00 idle, 1x illegal
//   rd_valid_o   out  FIFO head valid
//   rd_ready_i   in   consumer accepts head
//   rd_data_o    out  FIFO head payload (don't-care while empty)
//   count_o      out  occupancy
//   full_o       out  occupancy == DEPTH
//   empty_o      out  occupancy == 0
//   irq_o        out  registered, high while occupancy >= WATERMARK
//   overflow_o   out  sticky, a result was dropped while full
//   proto_err_o  out  sticky, an illegal res_en_i code was seen
//   clear_i      in   synchronous flush of FIFO and sticky flags
//   push_cnt_o   out  (stats only) accepted pushes, saturating
//   drop_cnt_o   out  (stats only) overflow drops, saturating
// -----------------------------------------------------------------------------
module custom_axi_result_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int WATERMARK  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH:0]          res_data_i,
  input  logic [1:0]                   res_en_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         irq_o,
  output logic                         overflow_o,
  output logic                         proto_err_o,
  input  logic                         clear_i
`ifdef CUSTOM_AXI_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]                  push_cnt_o,
  output logic [15:0]                  drop_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_irq;
  logic                  r_ovf;
  logic                  r_perr;

  logic                  w_push_req;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_illegal;
  logic [CW-1:0]         w_count_nxt;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = (res_en_i == 2'b01) && res_data_i[0];
  assign w_illegal  = res_en_i[1];

  // Clear discards any push or pop in the same cycle.
  assign w_pop  = !clear_i && !w_empty && rd_ready_i;
  // A full FIFO still accepts a push if the head leaves in the same cycle.
  assign w_push = !clear_i && w_push_req && (!w_full || w_pop);
  assign w_drop = !clear_i && w_push_req && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (clear_i) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      // irq is registered from the next-state count so it moves with count_o.
      r_irq   <= (w_count_nxt >= CW'(WATERMARK));
      if (clear_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_ovf  <= 1'b0;
        r_perr <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        if (w_drop) r_ovf  <= 1'b1;
        if (w_illegal) r_perr <= 1'b1;
      end
    end
  end

  // Storage array carries no reset; clear leaves contents untouched.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= res_data_i[DATA_WIDTH:1];
    end
  end

  assign rd_data_o   = r_mem[r_rptr];
  assign rd_valid_o  = !w_empty;
  assign count_o     = r_count;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign irq_o       = r_irq;
  assign overflow_o  = r_ovf;
  assign proto_err_o = r_perr;

`ifdef CUSTOM_AXI_RESULT_FIFO_STATS_EN
  logic [15:0] r_push_cnt;
  logic [15:0] r_drop_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_push_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (clear_i) begin
      r_push_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_push_cnt <= sat_inc(r_push_cnt);
      if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign push_cnt_o = r_push_cnt;
  assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_custom_axi_result_fifo.sv
// -----------------------------------------------------------------------------
// Self-checking bench for custom_axi_result_fifo. The reference model is a
// plain queue holding the FIFO contents plus model flag bits; a separate
// monitor pops and compares the payload whenever the DUT hands over a word.
// -----------------------------------------------------------------------------
module tb_custom_axi_result_fifo;

  localparam int DEPTH      = 8;
  localparam int DATA_WIDTH = 16;
  localparam int WATERMARK  = 4;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [DATA_WIDTH:0]   res_data_i;
  logic [1:0]            res_en_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [CW-1:0]         count_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  irq_o;
  logic                  overflow_o;
  logic                  proto_err_o;
  logic                  clear_i;
`ifdef CUSTOM_AXI_RESULT_FIFO_STATS_EN
  logic [15:0]           push_cnt_o;
  logic [15:0]           drop_cnt_o;
`endif

  custom_axi_result_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .WATERMARK(WATERMARK)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .res_data_i(res_data_i), .res_en_i(res_en_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .irq_o(irq_o),
    .overflow_o(overflow_o), .proto_err_o(proto_err_o), .clear_i(clear_i)
`ifdef CUSTOM_AXI_RESULT_FIFO_STATS_EN
    , .push_cnt_o(push_cnt_o), .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [DATA_WIDTH-1:0] sb[$];
  bit                    m_ovf, m_perr;
  int unsigned           m_push, m_drop;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int sz;
    sz = sb.size();
    chk("count", 32'(count_o), 32'(sz));
    chk("full", 32'(full_o), 32'(sz == DEPTH));
    chk("empty", 32'(empty_o), 32'(sz == 0));
    chk("rd_valid", 32'(rd_valid_o), 32'(sz != 0));
    chk("irq", 32'(irq_o), 32'(sz >= WATERMARK));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("proto_err", 32'(proto_err_o), 32'(m_perr));
    if (sz > 0) chk("head", 32'(rd_data_o), 32'(sb[0]));
`ifdef CUSTOM_AXI_RESULT_FIFO_STATS_EN
    chk("push_cnt", 32'(push_cnt_o), m_push);
    chk("drop_cnt", 32'(drop_cnt_o), m_drop);
`endif
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf = 0; m_perr = 0; m_push = 0; m_drop = 0;
  endtask

  // Check current state, drive one cycle of stimulus, record expectations.
  task automatic cycle(input logic [1:0] en, input logic [DATA_WIDTH:0] d,
                       input logic rdy, input logic clr);
    bit pop, req;
    check_status();
    res_en_i = en; res_data_i = d; rd_ready_i = rdy; clear_i = clr;
    pop = (sb.size() > 0) && rdy;
    req = (en == 2'b01) && d[0];
    if (clr) begin
      model_reset();
    end else begin
      if (en[1]) m_perr = 1;
      if (req) begin
        if (sb.size() < DEPTH || pop) begin
          sb.push_back(d[DATA_WIDTH:1]);
          if (m_push < 32'hFFFF) m_push++;
        end else begin
          m_ovf = 1;
          if (m_drop < 32'hFFFF) m_drop++;
        end
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(2'b00, '0, rdy, 1'b0);
  endtask

  task automatic push(input logic [DATA_WIDTH-1:0] p, input logic rdy);
    cycle(2'b01, {p, 1'b1}, rdy, 1'b0);
  endtask

  // Monitor: every handshake must deliver the oldest expected payload.
  always @(negedge clk_i) begin
    if (!rst_i && !clear_i && rd_valid_o && rd_ready_i) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL pop_unexpected: got %0h expected no word", rd_data_o);
      end else begin
        chk("pop_data", 32'(rd_data_o), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] en;
    logic [DATA_WIDTH:0] d;
    int r;
    rst_i = 1'b1; res_en_i = '0; res_data_i = '0; rd_ready_i = 1'b0; clear_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    check_status();

    // Three results, payload is bits [16:1]
    cycle(2'b01, 17'h00035, 1'b0, 1'b0);
    cycle(2'b01, 17'h00057, 1'b0, 1'b0);
    cycle(2'b01, 17'h00079, 1'b0, 1'b0);
    chk("first_head", 32'(rd_data_o), 32'h001A);
    chk("count3", 32'(count_o), 32'd3);
    repeat (4) idle(1'b1);

    // Fill, then overflow with a ninth
    for (int i = 0; i < DEPTH; i++) push(16'(16'h0100 + i), 1'b0);
    push(16'hDEAD, 1'b0);
    idle(1'b0);
    chk("ovf_full", 32'(full_o), 32'd1);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    repeat (DEPTH + 1) idle(1'b1);

    // Clear, refill, push and pop together while full
    cycle(2'b00, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) push(16'(16'h0200 + i), 1'b0);
    push(16'hBEEF, 1'b1);
    chk("pp_count", 32'(count_o), 32'(DEPTH));
    repeat (DEPTH + 1) idle(1'b1);

    // Ignored result, then illegal enable, then clear
    cycle(2'b01, 17'h12344, 1'b0, 1'b0);
    cycle(2'b11, 17'h12345, 1'b0, 1'b0);
    idle(1'b0);
    chk("perr_set", 32'(proto_err_o), 32'd1);
    cycle(2'b00, '0, 1'b0, 1'b1);
    idle(1'b0);

    // Watermark crossing
    for (int i = 0; i < WATERMARK; i++) push(16'(16'h0300 + i), 1'b0);
    chk("irq_rise", 32'(irq_o), 32'd1);
    idle(1'b1);
    chk("irq_fall", 32'(irq_o), 32'd0);

    // Hold five, reset mid-cycle
    push(16'h0400, 1'b0);
    push(16'h0401, 1'b0);
    idle(1'b0);
    check_status();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    model_reset();
    @(posedge clk_i); #1 rst_i = 1'b0;

    // Clear with a simultaneous push
    cycle(2'b01, 17'h0AAAB, 1'b0, 1'b1);
    idle(1'b0);

    // Randomized traffic, two consumer-speed phases
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 300; i++) begin
        r = $urandom_range(0, 15);
        en = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r < 5) ? 2'b00 : 2'b01;
        d = (DATA_WIDTH + 1)'($urandom);
        d[0] = ($urandom_range(0, 4) != 0);
        cycle(en, d, (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 63) == 0));
      end
    end
    repeat (DEPTH + 2) idle(1'b1);
    check_status();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
